mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and shared-memory buses around mem_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment
// (both requesters plus the memory).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Instruction port
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    // Data port
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [BE_WIDTH-1:0]   d_byte_enable;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  d_error;

    // Shared memory port
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata, d_byte_enable,
        output d_rdata, d_resp, d_error,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata, d_byte_enable,
        input  d_rdata, d_resp, d_error,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction fetch port and a load/store port
// share one memory port. Round-robin on contention, one transaction at a time,
// all memory-side and response outputs registered.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic GrantI = 1'b0;
    localparam logic GrantD = 1'b1;

    typedef enum logic [1:0] {StIdle, StServeI, StServeD, StDone} state_e;

    state_e                state_q;
    logic                  last_grant_q;
    logic                  err_q;        // both d_read and d_write seen at grant
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  i_resp_q;
    logic                  d_resp_q;
    logic                  d_error_q;

    logic d_req;
    logic grant_d;

    // Data wins when it is the only requester or when instruction was served last.
    always_comb begin
        d_req   = bus.d_read | bus.d_write;
        grant_d = d_req & (~bus.i_read | (last_grant_q == GrantI));
    end

    // Arbitration FSM; every output is a register so nothing live leaks to memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= GrantI;
            err_q        <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            d_error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        state_q      <= StServeD;
                        last_grant_q <= GrantD;
                        addr_q       <= bus.d_addr;
                        wdata_q      <= bus.d_wdata;
                        be_q         <= bus.d_byte_enable;
                        // A conflicting read+write request is resolved as a write.
                        mem_write_q  <= bus.d_write;
                        mem_read_q   <= ~bus.d_write;
                        err_q        <= bus.d_read & bus.d_write;
                    end else if (bus.i_read) begin
                        state_q      <= StServeI;
                        last_grant_q <= GrantI;
                        addr_q       <= bus.i_addr;
                        wdata_q      <= '0;
                        be_q         <= '0;
                        mem_read_q   <= 1'b1;
                        mem_write_q  <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                StServeI, StServeD: begin
                    if (bus.mem_resp) begin
                        state_q     <= StDone;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state_q == StServeI) begin
                            i_rdata_q <= bus.mem_rdata;
                            i_resp_q  <= 1'b1;
                        end else begin
                            if (!mem_write_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                            d_resp_q  <= 1'b1;
                            d_error_q <= err_q;
                        end
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    i_resp_q  <= 1'b0;
                    d_resp_q  <= 1'b0;
                    d_error_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Drive the bus purely from registered state.
    always_comb begin
        bus.mem_read        = mem_read_q;
        bus.mem_write       = mem_write_q;
        bus.mem_address     = addr_q;
        bus.mem_wdata       = wdata_q;
        bus.mem_byte_enable = be_q;
        bus.i_rdata         = i_rdata_q;
        bus.i_resp          = i_resp_q;
        bus.d_rdata         = d_rdata_q;
        bus.d_resp          = d_resp_q;
        bus.d_error         = d_error_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a stimulus process pushes expected responses,
// a memory responder answers strobes, and a monitor pops and compares on every resp.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    logic model_resp;
    logic stray_resp;
    int   mem_delay;
    int   checks;
    int   failures;

    typedef struct {
        bit          is_d;
        bit          is_wr;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_i;
    logic [31:0] m_d;

    // Last transaction the memory responder completed.
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_wr;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_resp = model_resp | stray_resp;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h60) return 32'h0000_0013;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_d, input bit is_wr, input bit err, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        if (!is_wr) begin
            if (is_d) m_d = mem_model(addr);
            else m_i = mem_model(addr);
        end
        e.is_d = is_d; e.is_wr = is_wr; e.err = err;
        e.addr = addr; e.wdata = wdata; e.be = be;
        e.i_rdata = m_i; e.d_rdata = m_d;
        sb_q.push_back(e);
    endtask

    task automatic wait_resp(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) begin
                found = 1'b1;
                break;
            end
        end
        check(name, {31'b0, found}, 32'd1);
    endtask

    task automatic idle_inputs();
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_byte_enable = '0;
    endtask

    // Memory model: answers each strobe after mem_delay cycles, checks bus stability.
    int          cnt;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_wr;
    always @(negedge clk) begin
        model_resp    = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        if (!rst) begin
            cnt = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            check("one_strobe", {31'b0, bus.mem_read ^ bus.mem_write}, 32'd1);
            if (cnt == 0) begin
                snap_addr = bus.mem_address; snap_wdata = bus.mem_wdata;
                snap_be = bus.mem_byte_enable; snap_wr = bus.mem_write;
            end else begin
                check("stable_addr", bus.mem_address, snap_addr);
                check("stable_wdata", bus.mem_wdata, snap_wdata);
                check("stable_be", {28'b0, bus.mem_byte_enable}, {28'b0, snap_be});
                check("stable_op", {31'b0, bus.mem_write}, {31'b0, snap_wr});
            end
            cnt++;
            if (cnt >= mem_delay) begin
                model_resp    = 1'b1;
                bus.mem_rdata = bus.mem_write ? 32'hBAD0_BAD0 : mem_model(bus.mem_address);
                seen_addr = bus.mem_address; seen_wdata = bus.mem_wdata;
                seen_be = bus.mem_byte_enable; seen_wr = bus.mem_write;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response pulse appears.
    bit prev_resp = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.i_resp || bus.d_resp) begin
            check("resp_not_adjacent", {31'b0, prev_resp}, 32'd0);
            check("resp_onehot", {31'b0, bus.i_resp & bus.d_resp}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b with no pending transaction",
                         bus.i_resp, bus.d_resp);
            end else begin
                e = sb_q.pop_front();
                check("resp_port", {31'b0, bus.d_resp}, {31'b0, e.is_d});
                check("i_rdata", bus.i_rdata, e.i_rdata);
                check("d_rdata", bus.d_rdata, e.d_rdata);
                check("d_error", {31'b0, bus.d_error}, {31'b0, e.err});
                check("mem_addr", seen_addr, e.addr);
                check("mem_op_write", {31'b0, seen_wr}, {31'b0, e.is_wr});
                if (e.is_wr) begin
                    check("mem_wdata", seen_wdata, e.wdata);
                    check("mem_be", {28'b0, seen_be}, {28'b0, e.be});
                end
            end
        end else if (bus.d_error) begin
            check("d_error_without_resp", {31'b0, bus.d_error}, 32'd0);
        end
        prev_resp = bus.i_resp | bus.d_resp;
    end

    initial begin
        int n;
        checks = 0; failures = 0;
        rst = 1'b0; model_resp = 1'b0; stray_resp = 1'b0; mem_delay = 1;
        m_i = '0; m_d = '0;
        idle_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_strobes", {27'b0, bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp,
                              bus.d_error}, 32'd0);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_be", {28'b0, bus.mem_byte_enable}, 32'd0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        rst = 1'b1;

        // Instruction fetch, memory answers with the strobe
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h60; mem_delay = 1;
        push(1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0);
        @(negedge clk);
        check("t1_strobe", {30'b0, bus.mem_read, bus.mem_write}, 32'd2);
        check("t1_addr", bus.mem_address, 32'h60);
        idle_inputs();
        @(negedge clk);
        check("t1_i_resp", {31'b0, bus.i_resp}, 32'd1);
        check("t1_i_rdata", bus.i_rdata, 32'h13);
        @(negedge clk);
        check("t1_idle", {28'b0, bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 32'd0);

        // Delayed store; live inputs scrambled after grant
        @(negedge clk);
        bus.d_write = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_byte_enable = 4'b0011; mem_delay = 3;
        push(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t2_write_held", {30'b0, bus.mem_read, bus.mem_write}, 32'd1);
            check("t2_addr", bus.mem_address, 32'h100);
            bus.d_write = 1'b0; bus.d_addr = 32'hFFF0; bus.d_wdata = 32'h0;
            bus.d_byte_enable = 4'hF;
        end
        @(negedge clk);
        check("t2_d_resp", {30'b0, bus.i_resp, bus.d_resp}, 32'd1);
        idle_inputs();
        @(negedge clk);

        // Round robin from reset with both ports requesting
        @(negedge clk);
        rst = 1'b0; m_i = '0; m_d = '0; mem_delay = 1;
        bus.i_read = 1'b1; bus.i_addr = 32'h200;
        bus.d_read = 1'b1; bus.d_addr = 32'h300;
        push(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
        push(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
        push(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
        push(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) n++;
        end
        check("t3_four_resps", n, 32'd4);
        idle_inputs();
        @(negedge clk);

        // Conflicting read+write resolves as write with error
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h400;
        bus.d_wdata = 32'h1234_5678; bus.d_byte_enable = 4'hF; mem_delay = 2;
        push(1'b1, 1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'hF);
        @(negedge clk);
        check("t4_write", {30'b0, bus.mem_read, bus.mem_write}, 32'd1);
        idle_inputs();
        wait_resp("t4_resp");
        check("t4_error_with_resp", {30'b0, bus.d_error, bus.d_resp}, 32'd3);
        @(negedge clk);

        // Reset mid-transaction, then instruction-only grant
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_addr = 32'h500; mem_delay = 10;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_async_clear", {27'b0, bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp,
                                 bus.d_error}, 32'd0);
        check("t5_async_addr", bus.mem_address, 32'd0);
        check("t5_async_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        m_i = '0; m_d = '0;
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h60; mem_delay = 1;
        push(1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_serve_i", {30'b0, bus.mem_read, bus.mem_write}, 32'd2);
        check("t5_addr", bus.mem_address, 32'h60);
        idle_inputs();
        wait_resp("t5_resp");
        @(negedge clk);

        // Stray mem_resp while idle
        @(negedge clk);
        stray_resp = 1'b1;
        @(negedge clk);
        stray_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_quiet", {28'b0, bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp},
                  32'd0);
        end

        // Data load after the stray pulse; i_rdata must hold
        bus.d_read = 1'b1; bus.d_addr = 32'h700; mem_delay = 2;
        push(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
        @(negedge clk);
        check("t7_read", {30'b0, bus.mem_read, bus.mem_write}, 32'd2);
        check("t7_addr", bus.mem_address, 32'h700);
        idle_inputs();
        wait_resp("t7_resp");

        // Drain
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
